// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the program-counter fetch block.
package pc_fetch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int          PC_W_DEF       = 16;
  localparam int          CNT_W_DEF      = 16;
  localparam logic [15:0] START_ADDR_DEF = 16'h0000;
endpackage

// File: rtl/pc_fetch_if.sv
// Control/status bundle between the sequencer (master) and pc_fetch (slave).
interface pc_fetch_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             branch;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, halt, stall, branch, branch_target,
    input  pc, fetch_valid, done, cycle_count
  );

  modport slave (
    input  start, halt, stall, branch, branch_target,
    output pc, fetch_valid, done, cycle_count
  );
endinterface

// File: rtl/pc_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // next count: clear, saturating increment, or hold
  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pc_fetch.sv
// Program-counter fetch sequencer: IDLE -> RUN -> HALTED with
// halt > stall > branch > increment priority while running.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
  parameter int              CNT_W      = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  pc_fetch_if.slave bus
);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_done;
  logic            w_cnt_clr;
  logic            w_cnt_en;

  // next-state and next-pc selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_ADDR;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        w_cnt_en = 1'b1;
        if (bus.halt) begin
          w_state_nxt = ST_HALTED;
        end else if (bus.stall) begin
          // a branch under stall is dropped; upstream presents it again
          w_pc_nxt = r_pc;
        end else if (bus.branch) begin
          w_pc_nxt = bus.branch_target;
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = START_ADDR;
      end
    endcase
  end

  // state, pc and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= START_ADDR;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= (w_state_nxt == ST_HALTED);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (bus.cycle_count)
  );

  assign bus.pc          = r_pc;
  assign bus.done        = r_done;
  assign bus.fetch_valid = (r_state == ST_RUN) && !bus.stall;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed plus randomized bench for pc_fetch against a behavioural model.
module tb_pc_fetch;
  localparam int PC_W    = 16;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int START   = 0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  // model: running / halted flags, pc and cycle count as plain integers
  bit m_run;
  bit m_halted;
  int m_pc;
  int m_cnt;

  pc_fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_fetch #(
    .PC_W       (PC_W),
    .START_ADDR (16'h0000),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_halted = 1'b0;
    m_pc     = START;
    m_cnt    = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"},   {16'd0, bus.pc}, m_pc);
    check({tag, ".done"}, {31'd0, bus.done}, {31'd0, m_halted});
    check({tag, ".cnt"},  {27'd0, bus.cycle_count}, m_cnt);
  endtask

  // One clock: drive inputs, check fetch_valid, clock, advance model, check regs.
  task automatic step(input bit s, input bit h, input bit st, input bit b,
                      input logic [15:0] tgt, input string tag);
    bus.start         = s;
    bus.halt          = h;
    bus.stall         = st;
    bus.branch        = b;
    bus.branch_target = tgt;
    #1;
    check({tag, ".fv"}, {31'd0, bus.fetch_valid}, {31'd0, m_run && !st});
    @(posedge clk);
    if (!m_run) begin
      if (s) begin
        m_run    = 1'b1;
        m_halted = 1'b0;
        m_pc     = START;
        m_cnt    = 0;
      end
    end else begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (h) begin
        m_run    = 1'b0;
        m_halted = 1'b1;
      end else if (!st) begin
        m_pc = b ? int'(tgt) : (m_pc + 1) % 65536;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic free(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
  endtask

  task automatic hard_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("rst_now");
    check("rst_now.fv", {31'd0, bus.fetch_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0;
    bus.branch = 1'b0; bus.branch_target = 16'h0000;
    model_reset();
    #3;
    check_regs("por");
    check("por.fv", {31'd0, bus.fetch_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle ignores halt/stall/branch
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, "idle_ign");

    // start then five free-running cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "start");
    check("start.pc0", {16'd0, bus.pc}, 32'h0000);
    free(5, "free5");
    check("free5.pc", {16'd0, bus.pc}, 32'h0005);
    check("free5.cnt", {27'd0, bus.cycle_count}, 32'd5);

    // branch at pc 3
    hard_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "start");
    free(3, "to3");
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, "br40");
    check("br40.pc", {16'd0, bus.pc}, 32'h0040);
    free(1, "after40");
    check("after40.pc", {16'd0, bus.pc}, 32'h0041);

    // stall masks branch for two cycles
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, "to10");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, "stall_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, "stall_b");
    check("stall.pc", {16'd0, bus.pc}, 32'h0010);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, "br80");
    check("br80.pc", {16'd0, bus.pc}, 32'h0080);

    // pc wrap at all-ones
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, "toFFFF");
    free(1, "wrap");
    check("wrap.pc", {16'd0, bus.pc}, 32'h0000);
    check("wrap.run", {31'd0, bus.fetch_valid}, 32'd1);

    // halt beats branch; halted ignores controls; start restarts
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, "to7");
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0099, "halt7");
    check("halt7.pc", {16'd0, bus.pc}, 32'h0007);
    check("halt7.done", {31'd0, bus.done}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0055, "halted_ign");
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "restart");
    check("restart.done", {31'd0, bus.done}, 32'd0);
    check("restart.cnt", {27'd0, bus.cycle_count}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "start_in_run");

    // reset between edges mid-run
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0022, "to22");
    hard_reset();
    free(2, "post_rst");
    check("post_rst.pc", {16'd0, bus.pc}, 32'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "resume");

    // counter saturation
    free(CNT_MAX + 4, "sat");
    check("sat.cnt", {27'd0, bus.cycle_count}, CNT_MAX);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
           16'($urandom_range(0, 65535)), "rnd");
      if ($urandom_range(0, 199) == 0) hard_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_W, 16, width of program counter and branch target.
REQ-002 Parameter START_ADDR, 16'h0000, PC loaded on start.
REQ-003 Parameter CNT_W, 16, width of cycle counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin execution at START_ADDR; sampled in IDLE and HALTED only.
REQ-007 halt  input  1  stop execution; sampled in RUN only.
REQ-008 stall  input  1  hold PC this cycle; sampled in RUN only.
REQ-009 branch  input  1  take branch; from branch-check stage, combinational off pc.
REQ-010 branch_target  input  PC_W  redirect address, valid when branch=1.
REQ-011 pc  output  PC_W  current fetch address, registered.
REQ-012 fetch_valid  output  1  high while state is RUN and stall=0.
REQ-013 done  output  1  high while state is HALTED, registered.
REQ-014 cycle_count  output  CNT_W  cycles spent in RUN, registered.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, HALTED.
REQ-016 IDLE: start=1 -> RUN next edge with pc<=START_ADDR and cycle_count<=0; otherwise hold.
REQ-017 RUN: per-edge priority halt > stall > branch > increment.
REQ-018 RUN, halt=1 -> HALTED, pc holds, done=1 from the next cycle.
REQ-019 RUN, halt=0, stall=1 -> pc holds; branch ignored that cycle (upstream re-presents it).
REQ-020 RUN, halt=0, stall=0, branch=1 -> pc<=branch_target.
REQ-021 RUN, no halt/stall/branch -> pc<=pc+1, modulo 2^PC_W (16'hFFFF wraps to 16'h0000, no flag).
REQ-022 start SHALL be ignored in RUN.
REQ-023 halt, stall and branch SHALL be ignored in IDLE and HALTED.
REQ-024 HALTED: done held high, pc held; start=1 -> RUN with pc<=START_ADDR, cycle_count<=0, done=0 next cycle.
REQ-025 cycle_count SHALL increment on every edge spent in RUN (stall cycles included, the halting edge included), and saturate at all-ones.
REQ-026 fetch_valid SHALL be combinational: (state==RUN) && !stall.
REQ-027 Latency: branch/increment effect visible on pc one cycle after the sampling edge; no bypass.

Reset
REQ-028 reset=1 SHALL force, without waiting for clk: state=IDLE, pc=START_ADDR, done=0, cycle_count=0.
REQ-029 fetch_valid SHALL be 0 while reset=1.
REQ-030 Reset asserted mid-RUN or mid-HALTED SHALL abandon execution; after deassertion the block waits in IDLE for start.

Structure
REQ-031 Shared package holds the state enum (IDLE, RUN, HALTED) and the START_ADDR default constant.
REQ-032 The saturating cycle counter SHALL be a sub-module named sat_counter (inputs clr, en; CNT_W parameter).
REQ-033 All registers in one always_ff with asynchronous reset; next-state/next-pc logic in always_comb.

Verification
REQ-034 Reset, start pulse, 5 free-running cycles -> pc 0,1,2,3,4,5; fetch_valid=1; cycle_count=5.
REQ-035 In RUN at pc=0x0003, branch=1 with target 0x0040 -> pc=0x0040 next cycle, then 0x0041.
REQ-036 At pc=0x0010, stall=1 and branch=1 (target 0x0080) for 2 cycles -> pc stays 0x0010, fetch_valid=0; then stall=0, branch=1 -> pc=0x0080.
REQ-037 pc preloaded via branch to 0xFFFF, one free cycle -> pc=0x0000, state stays RUN.
REQ-038 halt=1 and branch=1 together at pc=0x0007 -> HALTED, pc=0x0007, done=1; start -> pc=0x0000, done=0, cycle_count restarts at 0.
REQ-039 Reset asserted between clock edges mid-RUN at pc=0x0022 -> pc=0x0000, done=0, state IDLE immediately; start needed to resume.
